mlp_div_seq_43s_27s_16: RTL and testbench

- Iterative signed divider that undoes the MLP datapath's 16s x 27s -> 43s product scaling.
- Takes a 43-bit signed accumulator/product and a 27-bit signed scale, and returns a saturated 16-bit signed quotient plus a 27-bit remainder.
- Sits after the multiply/accumulate stage in the requantize path.
- Uses valid/ready handshakes on both sides and a ce clock-enable matching the multiplier pipeline.

---
 rtl/mlp_div_pkg.sv | 24 ++
 rtl/mlp_div_sat_fixup.sv | 45 ++++
 rtl/mlp_div_seq_43s_27s_16.sv | 148 ++++++++++++++
 tb/tb_mlp_div_seq_43s_27s_16.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mlp_div_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mlp_div_pkg: shared widths, saturation limits and FSM states for  |
// | the requantize divider.          Rev 1.0                          |
// +-------------------------------------------------------------------+
package mlp_div_pkg;

  localparam int DIVIDEND_W = 43;
  localparam int DIVISOR_W  = 27;
  localparam int QUOT_W     = 16;
  localparam int ITER_W     = $clog2(DIVIDEND_W);

  localparam logic [QUOT_W-1:0] QUOT_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0] QUOT_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mlp_div_sat_fixup.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mlp_div_sat_fixup: restores operand signs on the magnitude result |
// | and saturates the quotient.      Rev 1.0                          |
// +-------------------------------------------------------------------+
module mlp_div_sat_fixup
  import mlp_div_pkg::*;
(
  input  logic [DIVIDEND_W-1:0] quo_mag,
  input  logic [DIVISOR_W-1:0]  rem_mag,
  input  logic                  sign_dvd,
  input  logic                  sign_dvs,
  input  logic                  dbz,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf
);

  localparam logic [DIVIDEND_W-1:0] c_pos_lim = {{(DIVIDEND_W-QUOT_W){1'b0}}, QUOT_MAX};
  // Negative side may reach one further: -2^(QUOT_W-1) is a legal result.
  localparam logic [DIVIDEND_W-1:0] c_neg_lim = c_pos_lim + DIVIDEND_W'(1);

  logic                  w_q_neg;
  logic [DIVIDEND_W-1:0] w_q_twos;

  always_comb begin
    w_q_neg  = sign_dvd ^ sign_dvs;
    w_q_twos = -quo_mag;
    quotient = w_q_neg ? w_q_twos[QUOT_W-1:0] : quo_mag[QUOT_W-1:0];
    ovf      = 1'b0;
    if (dbz) begin
      quotient = sign_dvd ? QUOT_MIN : QUOT_MAX;
      ovf      = 1'b1;
    end else if (w_q_neg && (quo_mag > c_neg_lim)) begin
      quotient = QUOT_MIN;
      ovf      = 1'b1;
    end else if (!w_q_neg && (quo_mag > c_pos_lim)) begin
      quotient = QUOT_MAX;
      ovf      = 1'b1;
    end
    remainder = sign_dvd ? -rem_mag : rem_mag;
  end

endmodule
`default_nettype wire

// File: rtl/mlp_div_seq_43s_27s_16.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | mlp_div_seq_43s_27s_16: iterative restoring 43s/27s divider with  |
// | saturated 16s quotient and valid/ready/ce.  Rev 1.0               |
// +-------------------------------------------------------------------+
module mlp_div_seq_43s_27s_16
  import mlp_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dbz
);

  state_t                r_state;
  logic [ITER_W-1:0]     r_iter;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W:0]    r_pr;
  logic                  r_sign_dvd;
  logic                  r_sign_dvs;
  logic                  r_dbz_job;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [QUOT_W-1:0]     r_quot;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_ovf;
  logic                  r_dbz;

  logic [DIVIDEND_W-1:0] w_dvd_mag;
  logic [DIVISOR_W-1:0]  w_dvs_mag;
  logic [DIVISOR_W:0]    w_shift;
  logic [DIVISOR_W+1:0]  w_diff;
  logic [DIVISOR_W-1:0]  w_rem_mag;
  logic [QUOT_W-1:0]     w_fix_quot;
  logic [DIVISOR_W-1:0]  w_fix_rem;
  logic                  w_fix_ovf;
  logic                  w_unused_pr_msb;

  assign w_dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

  // r_dvd doubles as the quotient register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign w_shift = {r_pr[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
  // Partial remainder stays below |divisor| <= 2^26, so its top bit is always clear.
  assign w_unused_pr_msb = r_pr[DIVISOR_W];

  // A zero divisor skips the shifts, so r_dvd still holds |dividend|.
  assign w_rem_mag = r_dbz_job ? r_dvd[DIVISOR_W-1:0] : r_pr[DIVISOR_W-1:0];

  mlp_div_sat_fixup u_fixup (
    .quo_mag   (r_dvd),
    .rem_mag   (w_rem_mag),
    .sign_dvd  (r_sign_dvd),
    .sign_dvs  (r_sign_dvs),
    .dbz       (r_dbz_job),
    .quotient  (w_fix_quot),
    .remainder (w_fix_rem),
    .ovf       (w_fix_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_iter      <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_pr        <= '0;
      r_sign_dvd  <= 1'b0;
      r_sign_dvs  <= 1'b0;
      r_dbz_job   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else if (ce) begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd      <= w_dvd_mag;
            r_dvs      <= w_dvs_mag;
            r_sign_dvd <= dividend[DIVIDEND_W-1];
            r_sign_dvs <= divisor[DIVISOR_W-1];
            r_pr       <= '0;
            r_iter     <= ITER_W'(DIVIDEND_W-1);
            r_dbz_job  <= (divisor == '0);
            r_in_ready <= 1'b0;
            r_state    <= (divisor == '0) ? FIXUP : BUSY;
          end
        end
        BUSY: begin
          if (w_diff[DIVISOR_W+1]) begin
            r_pr  <= w_shift;
            r_dvd <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
          end else begin
            r_pr  <= w_diff[DIVISOR_W:0];
            r_dvd <= {r_dvd[DIVIDEND_W-2:0], 1'b1};
          end
          if (r_iter == '0) begin
            r_state <= FIXUP;
          end else begin
            r_iter <= r_iter - ITER_W'(1);
          end
        end
        FIXUP: begin
          r_quot      <= w_fix_quot;
          r_rem       <= w_fix_rem;
          r_ovf       <= w_fix_ovf;
          r_dbz       <= r_dbz_job;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mlp_div_seq_43s_27s_16.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_mlp_div_seq_43s_27s_16: directed self-checking bench for the   |
// | requantize divider.              Rev 1.0                          |
// +-------------------------------------------------------------------+
module tb_mlp_div_seq_43s_27s_16;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               ce;
  logic               in_valid;
  logic               in_ready;
  logic [42:0]        dividend;
  logic [26:0]        divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] quotient;
  logic signed [26:0] remainder;
  logic               ovf;
  logic               dbz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mlp_div_seq_43s_27s_16 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Leaves the bench #1 after the accept edge.
  task automatic start_job(input string tag, input logic signed [63:0] dvd,
                           input logic signed [63:0] dvs, input bit hold);
    bit acc = 1'b0;
    dividend = dvd[42:0];
    divisor  = dvs[26:0];
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = in_ready && ce;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!hold) in_valid = 1'b0;
    if (!acc) chk({tag, "_accept"}, 64'd0, 64'd1);
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic wait_result(input string tag, input int eq, input int er,
                             input bit eovf, input bit edbz, input int elat);
    int lat = 1;
    bit rdy = in_ready;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
      rdy |= in_ready;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_ovf"}, ovf, eovf);
    chk({tag, "_dbz"}, dbz, edbz);
    chk({tag, "_in_ready_low"}, rdy, 1'b0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, out_valid, 1'b0);
    chk({tag, "_hs_flags"}, {ovf, dbz}, 2'b00);
    chk({tag, "_hs_ready"}, in_ready, 1'b1);
  endtask

  task automatic job(input string tag, input logic signed [63:0] dvd,
                     input logic signed [63:0] dvs, input int eq, input int er,
                     input bit eovf, input bit edbz, input int elat, input bit hold);
    start_job(tag, dvd, dvs, hold);
    wait_result(tag, eq, er, eovf, edbz, elat);
    handshake(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit stable;
    logic [15:0] q_hold;
    reset_n   = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_dbz", dbz, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    job("mil",  1000000, 1000, 1000, 0, 1'b0, 1'b0, 45, 1'b0);

    // Back-to-back with in_valid held high across jobs.
    job("b2b0", -7,  2, -3, -1, 1'b0, 1'b0, 45, 1'b1);
    job("b2b1",  7, -2, -3,  1, 1'b0, 1'b0, 45, 1'b1);
    job("b2b2", -7, -2,  3, -1, 1'b0, 1'b0, 45, 1'b0);

    job("sat_pos", 1048576, 1, 32767, 0, 1'b1, 1'b0, 45, 1'b0);
    job("min_ok",  -32768,  1, -32768, 0, 1'b0, 1'b0, 45, 1'b0);
    job("big_neg", -64'sd4398046511104, -1, 32767, 0, 1'b1, 1'b0, 45, 1'b0);

    job("dbz_pos",  5, 0,  32767,  5, 1'b1, 1'b1, 2, 1'b0);
    job("dbz_neg", -5, 0, -32768, -5, 1'b1, 1'b1, 2, 1'b0);

    // Backpressure: out_ready low, then ce low with out_ready high.
    start_job("bp", 1000, -3, 1'b0);
    wait_result("bp", -333, 1, 1'b0, 1'b0, 45);
    q_hold = quotient;
    stable = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!out_valid || quotient !== q_hold || remainder !== 27'sd1) stable = 1'b0;
    end
    chk("bp_hold_ready_low", stable, 1'b1);
    ce        = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (!out_valid || quotient !== q_hold || in_ready) stable = 1'b0;
    end
    chk("bp_hold_ce_low", stable, 1'b1);
    ce = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_hs_valid", out_valid, 1'b0);
    chk("bp_hs_ready", in_ready, 1'b1);

    // Reset in the middle of BUSY discards the job.
    start_job("rst", 123456, 789, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    job("after_rst", 100, 7, 14, 2, 1'b0, 1'b0, 45, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
